// File: rtl/element_tag_parser_if.sv
// Purpose: character-in / tag-record-out bundle for element_tag_parser.
// master: tokenizer side (drives start_i, char_valid_i, char_i; observes results).
// slave : parser side (observes the stream; drives busy/done/tag/attribute record).
interface element_tag_parser_if #(
    parameter int unsigned CHAR_W        = 8,
    parameter int unsigned ATTR_NAME_MAX = 12,
    parameter int unsigned VAL_MAX       = 16
);
    localparam int unsigned ANL_W = $clog2(ATTR_NAME_MAX + 1);
    localparam int unsigned AVL_W = $clog2(VAL_MAX + 1);

    logic                            start_i;
    logic                            char_valid_i;
    logic [CHAR_W-1:0]               char_i;
    logic                            busy_o;
    logic                            done_o;
    logic                            error_o;
    logic [3:0]                      tag_id_o;
    logic                            is_closing_o;
    logic                            is_self_closing_o;
    logic                            attr_valid_o;
    logic [ATTR_NAME_MAX*CHAR_W-1:0] attr_name_o;
    logic [ANL_W-1:0]                attr_name_len_o;
    logic [VAL_MAX*CHAR_W-1:0]       attr_value_o;
    logic [AVL_W-1:0]                attr_value_len_o;
    logic                            attr_truncated_o;

    modport master (
        output start_i, char_valid_i, char_i,
        input  busy_o, done_o, error_o, tag_id_o, is_closing_o, is_self_closing_o,
        input  attr_valid_o, attr_name_o, attr_name_len_o, attr_value_o,
        input  attr_value_len_o, attr_truncated_o
    );

    modport slave (
        input  start_i, char_valid_i, char_i,
        output busy_o, done_o, error_o, tag_id_o, is_closing_o, is_self_closing_o,
        output attr_valid_o, attr_name_o, attr_name_len_o, attr_value_o,
        output attr_value_len_o, attr_truncated_o
    );
endinterface

// File: rtl/element_tag_parser.sv
// Purpose: parses one markup tag (chars after '<' through '>'), resolves the
// case-folded tag name against a fixed table, flags closing/self-closing tags
// and emits each attribute as a name/value record.
// Ports: clock_i, reset_i (synchronous, active-high); bus (element_tag_parser_if.slave).
// Optional feature: define UNQUOTED_ATTR_EN to accept unquoted attribute values.
module element_tag_parser #(
    parameter int unsigned CHAR_W        = 8,
    parameter int unsigned NAME_MAX      = 8,
    parameter int unsigned ATTR_NAME_MAX = 12,
    parameter int unsigned VAL_MAX       = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    element_tag_parser_if.slave  bus
);
    localparam int unsigned NB_W  = NAME_MAX * CHAR_W;
    localparam int unsigned AN_W  = ATTR_NAME_MAX * CHAR_W;
    localparam int unsigned AV_W  = VAL_MAX * CHAR_W;
    localparam int unsigned NL_W  = $clog2(NAME_MAX + 1);
    localparam int unsigned ANL_W = $clog2(ATTR_NAME_MAX + 1);
    localparam int unsigned AVL_W = $clog2(VAL_MAX + 1);

    localparam logic [CHAR_W-1:0] C_SP = CHAR_W'(8'h20), C_TAB = CHAR_W'(8'h09);
    localparam logic [CHAR_W-1:0] C_CR = CHAR_W'(8'h0d), C_LF  = CHAR_W'(8'h0a);
    localparam logic [CHAR_W-1:0] C_SLASH = CHAR_W'(8'h2f), C_GT = CHAR_W'(8'h3e);
    localparam logic [CHAR_W-1:0] C_EQ = CHAR_W'(8'h3d), C_DASH = CHAR_W'(8'h2d);
    localparam logic [CHAR_W-1:0] C_DQ = CHAR_W'(8'h22), C_SQ = CHAR_W'(8'h27);

    typedef enum logic [3:0] {
        S_IDLE, S_FIRST, S_NAME, S_WS, S_ANAME, S_VSTART,
        S_VAL, S_UVAL, S_SLASH, S_ERR, S_FINISH
    } state_e;

    function automatic logic is_ws(input logic [CHAR_W-1:0] c);
        return (c == C_SP) || (c == C_TAB) || (c == C_CR) || (c == C_LF);
    endfunction

    function automatic logic is_upper(input logic [CHAR_W-1:0] c);
        return (c >= CHAR_W'(8'h41)) && (c <= CHAR_W'(8'h5a));
    endfunction

    function automatic logic is_letter(input logic [CHAR_W-1:0] c);
        return is_upper(c) || ((c >= CHAR_W'(8'h61)) && (c <= CHAR_W'(8'h7a)));
    endfunction

    function automatic logic is_digit(input logic [CHAR_W-1:0] c);
        return (c >= CHAR_W'(8'h30)) && (c <= CHAR_W'(8'h39));
    endfunction

    // Tag-table entry: up to four ASCII chars, first char in the low byte, zero padded.
    function automatic logic [NB_W-1:0] mk_name(input logic [31:0] s);
        logic [NB_W-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(NAME_MAX)) r[i*CHAR_W +: CHAR_W] = CHAR_W'(s[i*8 +: 8]);
        end
        return r;
    endfunction

    // Exact match works because the name buffer is zero-cleared at start.
    function automatic logic [3:0] tag_lookup(input logic [NB_W-1:0] nm, input logic ovf);
        logic [3:0] id;
        id = 4'd0;
        if (!ovf) begin
            if      (nm == mk_name(32'h0076_6964)) id = 4'd1; // div
            else if (nm == mk_name(32'h0000_0070)) id = 4'd2; // p
            else if (nm == mk_name(32'h7964_6f62)) id = 4'd3; // body
            else if (nm == mk_name(32'h0000_0061)) id = 4'd4; // a
            else if (nm == mk_name(32'h0067_6d69)) id = 4'd5; // img
            else if (nm == mk_name(32'h6e61_7073)) id = 4'd6; // span
        end
        return id;
    endfunction

    state_e             state_q, state_d;
    logic [NB_W-1:0]    name_buf_q, name_buf_d;
    logic [NL_W-1:0]    name_len_q, name_len_d;
    logic               name_ovf_q, name_ovf_d;
    logic               closing_q, closing_d;
    logic               attr_seen_q, attr_seen_d;
    logic [CHAR_W-1:0]  quote_q, quote_d;
    logic               busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [3:0]         tag_id_q, tag_id_d;
    logic               is_closing_q, is_closing_d, is_sc_q, is_sc_d;
    logic               attr_valid_q, attr_valid_d, attr_trunc_q, attr_trunc_d;
    logic [AN_W-1:0]    attr_name_q, attr_name_d;
    logic [ANL_W-1:0]   attr_name_len_q, attr_name_len_d;
    logic [AV_W-1:0]    attr_value_q, attr_value_d;
    logic [AVL_W-1:0]   attr_value_len_q, attr_value_len_d;

    logic [CHAR_W-1:0]  c;
    logic               consume, do_ws, to_err, fin, fin_err, fin_sc;
    logic               name_app, attr_start, aname_app, val_app;

    assign c       = bus.char_i;
    assign consume = busy_q && bus.char_valid_i;

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q          <= S_IDLE;
            name_buf_q       <= '0;
            name_len_q       <= '0;
            name_ovf_q       <= 1'b0;
            closing_q        <= 1'b0;
            attr_seen_q      <= 1'b0;
            quote_q          <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            tag_id_q         <= '0;
            is_closing_q     <= 1'b0;
            is_sc_q          <= 1'b0;
            attr_valid_q     <= 1'b0;
            attr_trunc_q     <= 1'b0;
            attr_name_q      <= '0;
            attr_name_len_q  <= '0;
            attr_value_q     <= '0;
            attr_value_len_q <= '0;
        end else begin
            state_q          <= state_d;
            name_buf_q       <= name_buf_d;
            name_len_q       <= name_len_d;
            name_ovf_q       <= name_ovf_d;
            closing_q        <= closing_d;
            attr_seen_q      <= attr_seen_d;
            quote_q          <= quote_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            error_q          <= error_d;
            tag_id_q         <= tag_id_d;
            is_closing_q     <= is_closing_d;
            is_sc_q          <= is_sc_d;
            attr_valid_q     <= attr_valid_d;
            attr_trunc_q     <= attr_trunc_d;
            attr_name_q      <= attr_name_d;
            attr_name_len_q  <= attr_name_len_d;
            attr_value_q     <= attr_value_d;
            attr_value_len_q <= attr_value_len_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        name_buf_d       = name_buf_q;
        name_len_d       = name_len_q;
        name_ovf_d       = name_ovf_q;
        closing_d        = closing_q;
        attr_seen_d      = attr_seen_q;
        quote_d          = quote_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        error_d          = error_q;
        tag_id_d         = tag_id_q;
        is_closing_d     = is_closing_q;
        is_sc_d          = is_sc_q;
        attr_valid_d     = 1'b0;
        attr_trunc_d     = attr_trunc_q;
        attr_name_d      = attr_name_q;
        attr_name_len_d  = attr_name_len_q;
        attr_value_d     = attr_value_q;
        attr_value_len_d = attr_value_len_q;
        do_ws      = 1'b0;
        to_err     = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        fin_sc     = 1'b0;
        name_app   = 1'b0;
        attr_start = 1'b0;
        aname_app  = 1'b0;
        val_app    = 1'b0;

        case (state_q)
            S_IDLE: if (bus.start_i) begin
                name_buf_d  = '0;
                name_len_d  = '0;
                name_ovf_d  = 1'b0;
                closing_d   = 1'b0;
                attr_seen_d = 1'b0;
                busy_d      = 1'b1;
                state_d     = S_FIRST;
            end
            S_FIRST: if (consume) begin
                if (c == C_SLASH) begin
                    closing_d = 1'b1;
                    state_d   = S_NAME;
                end else if (is_letter(c)) begin
                    name_app = 1'b1;
                    state_d  = S_NAME;
                end else to_err = 1'b1;
            end
            S_NAME: if (consume) begin
                if (is_letter(c) || is_digit(c)) name_app = 1'b1;
                else if (is_ws(c))               state_d = S_WS;
                else if (c == C_SLASH)           state_d = S_SLASH;
                else if (c == C_GT)              fin = 1'b1;
                else                             to_err = 1'b1;
            end
            S_WS: if (consume) do_ws = 1'b1;
            S_ANAME: if (consume) begin
                if (is_letter(c) || is_digit(c) || c == C_DASH) aname_app = 1'b1;
                else if (c == C_EQ) state_d = S_VSTART;
                else if (is_ws(c) || c == C_SLASH || c == C_GT) begin
                    // Boolean attribute: emit, then treat the terminator as whitespace-state input.
                    attr_valid_d = 1'b1;
                    do_ws        = 1'b1;
                end else to_err = 1'b1;
            end
            S_VSTART: if (consume) begin
                if (c == C_DQ || c == C_SQ) begin
                    quote_d = c;
                    state_d = S_VAL;
                end
`ifdef UNQUOTED_ATTR_EN
                else if (!is_ws(c) && c != C_GT) begin
                    val_app = 1'b1;
                    state_d = S_UVAL;
                end
`endif
                else to_err = 1'b1;
            end
            S_VAL: if (consume) begin
                if (c == quote_q) begin
                    attr_valid_d = 1'b1;
                    state_d      = S_WS;
                end else val_app = 1'b1;
            end
`ifdef UNQUOTED_ATTR_EN
            S_UVAL: if (consume) begin
                if (is_ws(c)) begin
                    attr_valid_d = 1'b1;
                    state_d      = S_WS;
                end else if (c == C_GT) begin
                    attr_valid_d = 1'b1;
                    fin          = 1'b1;
                end else if (c == C_DQ || c == C_SQ) to_err = 1'b1;
                else val_app = 1'b1;
            end
`endif
            S_SLASH: if (consume) begin
                if (c == C_GT) begin
                    fin    = 1'b1;
                    fin_sc = 1'b1;
                end else to_err = 1'b1;
            end
            S_ERR: if (consume && c == C_GT) begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (do_ws) begin
            if (is_ws(c))          state_d = S_WS;
            else if (c == C_SLASH) state_d = S_SLASH;
            else if (c == C_GT)    fin = 1'b1;
            else if (is_letter(c)) begin
                attr_start = 1'b1;
                state_d    = S_ANAME;
            end else to_err = 1'b1;
        end

        // A '>' that triggers an error also ends the tag; otherwise swallow until '>'.
        if (to_err) begin
            if (c == C_GT) begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end else state_d = S_ERR;
        end

        if (name_app) begin
            if (name_len_q < NL_W'(NAME_MAX)) begin
                name_buf_d[int'(name_len_q)*CHAR_W +: CHAR_W] = is_upper(c) ? c + CHAR_W'(32) : c;
                name_len_d = name_len_q + NL_W'(1);
            end else name_ovf_d = 1'b1;
        end

        if (attr_start) begin
            attr_seen_d                = 1'b1;
            attr_name_d                = '0;
            attr_name_d[CHAR_W-1:0]    = c;
            attr_name_len_d            = ANL_W'(1);
            attr_value_d               = '0;
            attr_value_len_d           = '0;
            attr_trunc_d               = 1'b0;
        end

        if (aname_app) begin
            if (attr_name_len_q < ANL_W'(ATTR_NAME_MAX)) begin
                attr_name_d[int'(attr_name_len_q)*CHAR_W +: CHAR_W] = c;
                attr_name_len_d = attr_name_len_q + ANL_W'(1);
            end else attr_trunc_d = 1'b1;
        end

        if (val_app) begin
            if (attr_value_len_q < AVL_W'(VAL_MAX)) begin
                attr_value_d[int'(attr_value_len_q)*CHAR_W +: CHAR_W] = c;
                attr_value_len_d = attr_value_len_q + AVL_W'(1);
            end else attr_trunc_d = 1'b1;
        end

        if (fin) begin
            state_d      = S_FINISH;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            tag_id_d     = tag_lookup(name_buf_q, name_ovf_q);
            is_closing_d = closing_q;
            is_sc_d      = fin_sc;
            // Closing tags may not carry attributes or end in "/>".
            error_d      = fin_err || (closing_q && (attr_seen_q || fin_sc));
        end
    end

    assign bus.busy_o            = busy_q;
    assign bus.done_o            = done_q;
    assign bus.error_o           = error_q;
    assign bus.tag_id_o          = tag_id_q;
    assign bus.is_closing_o      = is_closing_q;
    assign bus.is_self_closing_o = is_sc_q;
    assign bus.attr_valid_o      = attr_valid_q;
    assign bus.attr_name_o       = attr_name_q;
    assign bus.attr_name_len_o   = attr_name_len_q;
    assign bus.attr_value_o      = attr_value_q;
    assign bus.attr_value_len_o  = attr_value_len_q;
    assign bus.attr_truncated_o  = attr_trunc_q;
endmodule

// File: tb/tb_element_tag_parser.sv
// Purpose: directed self-checking bench for element_tag_parser (default parameters).
module tb_element_tag_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    element_tag_parser_if bus ();
    element_tag_parser dut (.clock_i(clk), .reset_i(rst), .bus(bus));

    typedef struct {
        logic [95:0]  n;
        logic [3:0]   nl;
        logic [127:0] v;
        logic [4:0]   vl;
        logic         t;
    } rec_t;

    rec_t q[$];
    int   total = 0, bad = 0, cyc = 0, done_cnt = 0, start_cyc = 0, d_cyc = 0;
    logic [3:0] d_tag;
    logic d_closing, d_sc, d_err, d_attr;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture attribute records and done results.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.attr_valid_o) begin
                rec_t r;
                r.n = bus.attr_name_o;   r.nl = bus.attr_name_len_o;
                r.v = bus.attr_value_o;  r.vl = bus.attr_value_len_o;
                r.t = bus.attr_truncated_o;
                q.push_back(r);
            end
            if (bus.done_o) begin
                done_cnt++;
                d_cyc = cyc; d_tag = bus.tag_id_o; d_closing = bus.is_closing_o;
                d_sc = bus.is_self_closing_o; d_err = bus.error_o; d_attr = bus.attr_valid_o;
            end
        end
    end

    function automatic logic [95:0] pk_n(input string s);
        logic [95:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < 12; i++) r[i*8 +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] pk_v(input string s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < 16; i++) r[i*8 +: 8] = s[i];
        return r;
    endfunction

    task automatic do_start();
        q.delete();
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bus.char_i = s[i];
            bus.char_valid_i = 1'b1;
            @(posedge clk); #1;
        end
        bus.char_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        for (int i = 0; i < 30; i++) begin
            if (done_cnt != base) break;
            @(negedge clk); #1;
        end
        ok = (done_cnt != base);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy_o); end
        total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done_o); end
        total++; if (bus.tag_id_o !== 4'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", bus.tag_id_o); end
        total++; if (bus.attr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_attr_valid got=%0b exp=0", bus.attr_valid_o); end
        total++; if (bus.attr_name_o !== '0) begin bad++; $display("FAIL reset_attr_name got=%h exp=0", bus.attr_name_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        int b = done_cnt;
        do_start();
        total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL div_busy got=%0b exp=1", bus.busy_o); end
        send_str("div>");
        // Done cycle: a start here must be ignored.
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        total++; if (done_cnt !== b + 1) begin bad++; $display("FAIL div_done_count got=%0d exp=%0d", done_cnt - b, 1); end
        // start sampled at edge 0, '>' at edge 4, done visible right after edge 4 (cycle 5).
        total++; if (d_cyc - start_cyc !== 4) begin bad++; $display("FAIL div_latency got=%0d exp=4", d_cyc - start_cyc); end
        total++; if (d_tag !== 4'd1) begin bad++; $display("FAIL div_tag got=%0d exp=1", d_tag); end
        total++; if (d_closing !== 1'b0 || d_err !== 1'b0) begin bad++; $display("FAIL div_flags got=%0b%0b exp=00", d_closing, d_err); end
        total++; if (q.size() !== 0) begin bad++; $display("FAIL div_no_attr got=%0d exp=0", q.size()); end
        total++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL div_after got=%0b%0b exp=00", bus.done_o, bus.busy_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_img();
        int b = done_cnt;
        bit ok;
        do_start();
        send_str("IMG src=\"a.png\" alt='x'/>");
        wait_done(b, ok);
        total++; if (!ok) begin bad++; $display("FAIL img_timeout got=no_done exp=done"); end
        total++; if (q.size() !== 2) begin bad++; $display("FAIL img_attr_count got=%0d exp=2", q.size()); end
        if (q.size() == 2) begin
            total++; if (q[0].n !== pk_n("src") || q[0].nl !== 4'd3) begin bad++; $display("FAIL img_a0_name got=%h/%0d exp=%h/3", q[0].n, q[0].nl, pk_n("src")); end
            total++; if (q[0].v !== pk_v("a.png") || q[0].vl !== 5'd5) begin bad++; $display("FAIL img_a0_val got=%h/%0d exp=%h/5", q[0].v, q[0].vl, pk_v("a.png")); end
            total++; if (q[1].n !== pk_n("alt") || q[1].nl !== 4'd3) begin bad++; $display("FAIL img_a1_name got=%h/%0d exp=%h/3", q[1].n, q[1].nl, pk_n("alt")); end
            total++; if (q[1].v !== pk_v("x") || q[1].vl !== 5'd1 || q[1].t !== 1'b0) begin bad++; $display("FAIL img_a1_val got=%h/%0d/%0b exp=%h/1/0", q[1].v, q[1].vl, q[1].t, pk_v("x")); end
        end
        total++; if (d_tag !== 4'd5) begin bad++; $display("FAIL img_tag got=%0d exp=5", d_tag); end
        total++; if (d_sc !== 1'b1 || d_err !== 1'b0) begin bad++; $display("FAIL img_sc_err got=%0b%0b exp=10", d_sc, d_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int b = done_cnt;
        string s = "/body>";
        bit ok;
        do_start();
        for (int i = 0; i < s.len(); i++) begin
            bus.char_i = s[i];
            bus.char_valid_i = 1'b1;
            @(posedge clk); #1;
            if (i < s.len() - 1) begin
                // Stalled '>' must not be consumed.
                bus.char_valid_i = 1'b0;
                bus.char_i = 8'h3e;
                @(posedge clk); #1;
                total++; if (bus.busy_o !== 1'b1 || done_cnt !== b) begin bad++; $display("FAIL stall_hold_%0d got=busy%0b/done%0d exp=busy1/done0", i, bus.busy_o, done_cnt - b); end
            end
        end
        bus.char_valid_i = 1'b0;
        wait_done(b, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=no_done exp=done"); end
        total++; if (d_tag !== 4'd3 || d_closing !== 1'b1 || d_err !== 1'b0) begin bad++; $display("FAIL stall_result got=tag%0d/cl%0b/err%0b exp=tag3/cl1/err0", d_tag, d_closing, d_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_trunc();
        int b = done_cnt;
        bit ok;
        do_start();
        send_str("p title=\"0123456789abcdefXYZ\">");
        wait_done(b, ok);
        total++; if (!ok) begin bad++; $display("FAIL trunc_timeout got=no_done exp=done"); end
        total++; if (q.size() !== 1) begin bad++; $display("FAIL trunc_attr_count got=%0d exp=1", q.size()); end
        if (q.size() == 1) begin
            total++; if (q[0].vl !== 5'd16 || q[0].t !== 1'b1) begin bad++; $display("FAIL trunc_len got=%0d/%0b exp=16/1", q[0].vl, q[0].t); end
            total++; if (q[0].v !== pk_v("0123456789abcdef")) begin bad++; $display("FAIL trunc_val got=%h exp=%h", q[0].v, pk_v("0123456789abcdef")); end
            total++; if (q[0].n !== pk_n("title") || q[0].nl !== 4'd5) begin bad++; $display("FAIL trunc_name got=%h/%0d exp=%h/5", q[0].n, q[0].nl, pk_n("title")); end
        end
        total++; if (d_tag !== 4'd2 || d_err !== 1'b0) begin bad++; $display("FAIL trunc_tag got=%0d/%0b exp=2/0", d_tag, d_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_unquoted();
        int b = done_cnt;
        bit ok;
        do_start();
        send_str("a href=x>");
        wait_done(b, ok);
        total++; if (!ok) begin bad++; $display("FAIL unq_timeout got=no_done exp=done"); end
`ifdef UNQUOTED_ATTR_EN
        total++; if (q.size() !== 1 || d_attr !== 1'b1 || d_err !== 1'b0) begin bad++; $display("FAIL unq_result got=n%0d/same%0b/err%0b exp=n1/same1/err0", q.size(), d_attr, d_err); end
        if (q.size() == 1) begin
            total++; if (q[0].n !== pk_n("href") || q[0].v !== pk_v("x") || q[0].vl !== 5'd1) begin bad++; $display("FAIL unq_rec got=%h/%h exp=%h/%h", q[0].n, q[0].v, pk_n("href"), pk_v("x")); end
        end
`else
        total++; if (q.size() !== 0 || d_err !== 1'b1) begin bad++; $display("FAIL unq_result got=n%0d/err%0b exp=n0/err1", q.size(), d_err); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_closing_attr();
        int b = done_cnt;
        bit ok;
        do_start();
        send_str("/p x>");
        wait_done(b, ok);
        total++; if (!ok) begin bad++; $display("FAIL clattr_timeout got=no_done exp=done"); end
        total++; if (q.size() !== 1 || d_attr !== 1'b1) begin bad++; $display("FAIL clattr_emit got=n%0d/same%0b exp=n1/same1", q.size(), d_attr); end
        if (q.size() == 1) begin
            total++; if (q[0].n !== pk_n("x") || q[0].nl !== 4'd1 || q[0].vl !== 5'd0) begin bad++; $display("FAIL clattr_rec got=%h/%0d/%0d exp=%h/1/0", q[0].n, q[0].nl, q[0].vl, pk_n("x")); end
        end
        total++; if (d_err !== 1'b1 || d_closing !== 1'b1 || d_tag !== 4'd2) begin bad++; $display("FAIL clattr_flags got=err%0b/cl%0b/tag%0d exp=err1/cl1/tag2", d_err, d_closing, d_tag); end
        @(posedge clk); #1;
    endtask

    task automatic test_unknown();
        int b = done_cnt;
        bit ok;
        do_start();
        send_str("section>");
        wait_done(b, ok);
        total++; if (!ok || d_tag !== 4'd0 || d_err !== 1'b0) begin bad++; $display("FAIL unknown_tag got=ok%0b/tag%0d/err%0b exp=ok1/tag0/err0", ok, d_tag, d_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int b = done_cnt;
        bit ok;
        do_start();
        send_str("div cl");
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.attr_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_ctrl got=%0b%0b%0b exp=000", bus.busy_o, bus.done_o, bus.attr_valid_o); end
        total++; if (bus.attr_name_o !== '0 || bus.attr_name_len_o !== 4'd0 || bus.tag_id_o !== 4'd0) begin bad++; $display("FAIL rmid_data got=%h/%0d/%0d exp=0/0/0", bus.attr_name_o, bus.attr_name_len_o, bus.tag_id_o); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (done_cnt !== b || bus.busy_o !== 1'b0) begin bad++; $display("FAIL rmid_no_done got=%0d/%0b exp=0/0", done_cnt - b, bus.busy_o); end
        do_start();
        send_str("span>");
        wait_done(b, ok);
        total++; if (!ok || d_tag !== 4'd6) begin bad++; $display("FAIL rmid_span got=ok%0b/tag%0d exp=ok1/tag6", ok, d_tag); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.char_valid_i = 1'b0;
        bus.char_i = '0;
        test_reset();
        test_div();
        test_img();
        test_stall();
        test_trunc();
        test_unquoted();
        test_closing_attr();
        test_unknown();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
